stat_counter_bank: RTL and testbench

//  Parametrised multi-lane statistics counter. Per cycle it counts valid input words with even

---
 rtl/stat_counter_bank.sv | 118 +++++++++++
 tb/tb_stat_counter_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_counter_bank.sv
// Multi-lane statistics counter: counts valid even-parity words and pattern matches per cycle,
// with sticky overflow, saturate/wrap mode and a req/ack snapshot port with optional read-and-clear.
module stat_counter_bank #(
    parameter int NUM_LANES   = 4,
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 16,
    parameter bit SATURATE    = 1'b1,
    parameter bit CLR_ON_SNAP = 1'b0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [NUM_LANES-1:0]        valid_in,
    input  logic [NUM_LANES*DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0]           pattern_a,
    input  logic [DATA_W-1:0]           pattern_b,
    input  logic                        snap_req,
    input  logic                        snap_ack,
    output logic [CNT_W-1:0]            even_cnt,
    output logic [CNT_W-1:0]            pat_cnt,
    output logic                        overflow,
    output logic                        snap_valid,
    output logic [CNT_W-1:0]            snap_even,
    output logic [CNT_W-1:0]            snap_pat,
    output logic                        snap_ovf
);

    localparam int INC_W = $clog2(NUM_LANES + 1);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t             state, state_next;
    logic               capture;
    logic [INC_W-1:0]   even_inc, pat_inc;
    logic [CNT_W:0]     even_sum, pat_sum;
    logic [DATA_W-1:0]  lane;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        even_inc = '0;
        pat_inc  = '0;
        lane     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane = data_in[i*DATA_W +: DATA_W];
            if (valid_in[i] && ~^lane)
                even_inc = even_inc + INC_W'(1);
            if (valid_in[i] && (lane == pattern_a || lane == pattern_b))
                pat_inc = pat_inc + INC_W'(1);
        end
    end

    // One extra bit catches the carry used for both the overflow flag and saturation.
    assign even_sum = {1'b0, even_cnt} + (CNT_W+1)'(even_inc);
    assign pat_sum  = {1'b0, pat_cnt}  + (CNT_W+1)'(pat_inc);

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (snap_req)              state_next = HOLD;
            HOLD: if (snap_ack && !snap_req) state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        case (state)
            IDLE:    capture = snap_req;
            HOLD:    capture = snap_ack && snap_req;
            default: capture = 1'b0;
        endcase
    end

    // The state bit itself is the registered snapshot-valid flag.
    assign snap_valid = (state == HOLD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            even_cnt <= '0;
            pat_cnt  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            even_cnt <= '0;
            pat_cnt  <= '0;
            overflow <= 1'b0;
        end else if (CLR_ON_SNAP && capture) begin
            // Read-and-clear keeps this cycle's events rather than dropping them.
            even_cnt <= CNT_W'(even_inc);
            pat_cnt  <= CNT_W'(pat_inc);
            overflow <= 1'b0;
        end else begin
            even_cnt <= (SATURATE && even_sum[CNT_W]) ? '1 : even_sum[CNT_W-1:0];
            pat_cnt  <= (SATURATE && pat_sum[CNT_W])  ? '1 : pat_sum[CNT_W-1:0];
            overflow <= overflow | even_sum[CNT_W] | pat_sum[CNT_W];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_even <= '0;
            snap_pat  <= '0;
            snap_ovf  <= 1'b0;
        end else if (capture) begin
            snap_even <= even_cnt;
            snap_pat  <= pat_cnt;
            snap_ovf  <= overflow;
        end
    end

endmodule

// File: tb/tb_stat_counter_bank.sv
// Directed bench for stat_counter_bank: three instances (saturate, wrap, read-and-clear) share stimulus;
// expected values are queued before each edge and popped and compared just after it.
module tb_stat_counter_bank;

    localparam int CW = 4;

    typedef enum int {S_EVEN, S_PAT, S_OVF, S_SVALID, S_SEVEN, S_SPAT, S_SOVF} sig_e;

    typedef struct {
        string         tag;
        int            inst;
        sig_e          sig;
        logic [CW-1:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic [1:0]    valid_in;
    logic [15:0]   data_in;
    logic [7:0]    pattern_a, pattern_b;
    logic          snap_req, snap_ack;

    logic [CW-1:0] even_cnt[3], pat_cnt[3], snap_even[3], snap_pat[3];
    logic          overflow[3], snap_valid[3], snap_ovf[3];

    always #5 clock = ~clock;

    stat_counter_bank #(.NUM_LANES(2), .DATA_W(8), .CNT_W(CW), .SATURATE(1), .CLR_ON_SNAP(0)) dut_sat (
        .clock(clock), .reset(reset), .clear(clear), .valid_in(valid_in), .data_in(data_in),
        .pattern_a(pattern_a), .pattern_b(pattern_b), .snap_req(snap_req), .snap_ack(snap_ack),
        .even_cnt(even_cnt[0]), .pat_cnt(pat_cnt[0]), .overflow(overflow[0]), .snap_valid(snap_valid[0]),
        .snap_even(snap_even[0]), .snap_pat(snap_pat[0]), .snap_ovf(snap_ovf[0]));

    stat_counter_bank #(.NUM_LANES(2), .DATA_W(8), .CNT_W(CW), .SATURATE(0), .CLR_ON_SNAP(0)) dut_wrap (
        .clock(clock), .reset(reset), .clear(clear), .valid_in(valid_in), .data_in(data_in),
        .pattern_a(pattern_a), .pattern_b(pattern_b), .snap_req(snap_req), .snap_ack(snap_ack),
        .even_cnt(even_cnt[1]), .pat_cnt(pat_cnt[1]), .overflow(overflow[1]), .snap_valid(snap_valid[1]),
        .snap_even(snap_even[1]), .snap_pat(snap_pat[1]), .snap_ovf(snap_ovf[1]));

    stat_counter_bank #(.NUM_LANES(2), .DATA_W(8), .CNT_W(CW), .SATURATE(1), .CLR_ON_SNAP(1)) dut_cos (
        .clock(clock), .reset(reset), .clear(clear), .valid_in(valid_in), .data_in(data_in),
        .pattern_a(pattern_a), .pattern_b(pattern_b), .snap_req(snap_req), .snap_ack(snap_ack),
        .even_cnt(even_cnt[2]), .pat_cnt(pat_cnt[2]), .overflow(overflow[2]), .snap_valid(snap_valid[2]),
        .snap_even(snap_even[2]), .snap_pat(snap_pat[2]), .snap_ovf(snap_ovf[2]));

    function automatic logic [CW-1:0] observe(input int inst, input sig_e sig);
        case (sig)
            S_EVEN:   return even_cnt[inst];
            S_PAT:    return pat_cnt[inst];
            S_OVF:    return {3'b000, overflow[inst]};
            S_SVALID: return {3'b000, snap_valid[inst]};
            S_SEVEN:  return snap_even[inst];
            S_SPAT:   return snap_pat[inst];
            default:  return {3'b000, snap_ovf[inst]};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int inst, input sig_e sig, input logic [CW-1:0] val);
        exp_t e;
        e.tag  = tag;
        e.inst = inst;
        e.sig  = sig;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic expect_zero(input string tag);
        for (int i = 0; i < 3; i++)
            for (int s = 0; s < 7; s++)
                expect_val(tag, i, sig_e'(s), '0);
    endtask

    task automatic compare_all();
        exp_t          e;
        logic [CW-1:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.inst, e.sig);
            n_tests++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s inst%0d %s: observed %0h expected %0h", e.tag, e.inst, e.sig.name(), obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic lanes(input logic [1:0] v, input logic [7:0] l1, input logic [7:0] l0);
        valid_in = v;
        data_in  = {l1, l0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
        pattern_a = 8'hAA; pattern_b = 8'h55;
        lanes(2'b00, 8'h00, 8'h00);
        #3;
        expect_zero("reset_state");
        compare_all();
        reset = 1'b0;

        // Even parity counting with per-lane qualifier
        lanes(2'b11, 8'h00, 8'h03);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                for (int k = 0; k < 3; k++) begin
                    expect_val("even_3cyc", k, S_EVEN, 4'd6);
                    expect_val("pat_3cyc", k, S_PAT, 4'd0);
                end
            end
            tick();
        end
        lanes(2'b01, 8'h03, 8'h01);
        expect_val("valid_mask_even", 0, S_EVEN, 4'd6);
        expect_val("valid_mask_pat", 0, S_PAT, 4'd0);
        tick();
        lanes(2'b11, 8'h01, 8'h03);
        for (int k = 0; k < 3; k++) expect_val("even_7", k, S_EVEN, 4'd7);
        tick();

        // Asynchronous reset mid-count
        #2 reset = 1'b1;
        #1;
        expect_zero("async_reset");
        compare_all();
        expect_zero("reset_held");
        tick();
        reset = 1'b0;

        // Pattern matching
        lanes(2'b11, 8'h55, 8'hAA);
        for (int k = 0; k < 3; k++) begin
            expect_val("pat_match", k, S_PAT, 4'd2);
            expect_val("pat_even", k, S_EVEN, 4'd2);
        end
        tick();
        lanes(2'b01, 8'h00, 8'h5A);
        expect_val("pat_nomatch", 0, S_PAT, 4'd2);
        expect_val("even_5a", 0, S_EVEN, 4'd3);
        tick();

        // Run up to 14, then overflow
        lanes(2'b11, 8'h00, 8'h00);
        repeat (5) tick();
        lanes(2'b01, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            expect_val("even_14", k, S_EVEN, 4'd14);
            expect_val("no_ovf_14", k, S_OVF, 4'd0);
        end
        tick();
        lanes(2'b11, 8'h00, 8'h00);
        expect_val("sat_even", 0, S_EVEN, 4'd15);
        expect_val("sat_ovf", 0, S_OVF, 4'd1);
        expect_val("wrap_even", 1, S_EVEN, 4'd0);
        expect_val("wrap_ovf", 1, S_OVF, 4'd1);
        expect_val("cos_sat_even", 2, S_EVEN, 4'd15);
        tick();
        expect_val("sat_hold", 0, S_EVEN, 4'd15);
        expect_val("wrap_cont", 1, S_EVEN, 4'd2);
        expect_val("wrap_ovf_sticky", 1, S_OVF, 4'd1);
        tick();
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_val("clear_even", k, S_EVEN, 4'd0);
            expect_val("clear_pat", k, S_PAT, 4'd0);
            expect_val("clear_ovf", k, S_OVF, 4'd0);
        end
        tick();
        clear = 1'b0;

        // Snapshot with read-and-clear
        lanes(2'b11, 8'h00, 8'h00);
        repeat (2) tick();
        lanes(2'b01, 8'h00, 8'h00);
        expect_val("cos_pre5", 2, S_EVEN, 4'd5);
        tick();
        snap_req = 1'b1;
        lanes(2'b11, 8'h00, 8'h00);
        expect_val("cos_snap_even", 2, S_SEVEN, 4'd5);
        expect_val("cos_reload", 2, S_EVEN, 4'd2);
        expect_val("cos_svalid", 2, S_SVALID, 4'd1);
        expect_val("cos_snap_ovf", 2, S_SOVF, 4'd0);
        expect_val("sat_snap_even", 0, S_SEVEN, 4'd5);
        expect_val("sat_no_reload", 0, S_EVEN, 4'd7);
        expect_val("sat_svalid", 0, S_SVALID, 4'd1);
        tick();
        expect_val("cos_req_ignored", 2, S_EVEN, 4'd4);
        expect_val("cos_snap_stable", 2, S_SEVEN, 4'd5);
        expect_val("sat_snap_stable", 0, S_SEVEN, 4'd5);
        expect_val("sat_even9", 0, S_EVEN, 4'd9);
        tick();
        snap_req = 1'b0; snap_ack = 1'b1;
        lanes(2'b00, 8'h00, 8'h00);
        expect_val("cos_ack_drop", 2, S_SVALID, 4'd0);
        expect_val("cos_data_kept", 2, S_SEVEN, 4'd5);
        expect_val("cos_even_kept", 2, S_EVEN, 4'd4);
        expect_val("sat_ack_drop", 0, S_SVALID, 4'd0);
        tick();
        expect_val("ack_in_idle", 0, S_SVALID, 4'd0);
        expect_val("ack_idle_data", 0, S_SEVEN, 4'd5);
        tick();
        snap_ack = 1'b0;

        // Clear and snapshot in the same cycle, then ack+req in HOLD
        clear = 1'b1;
        expect_val("clear2", 0, S_EVEN, 4'd0);
        tick();
        clear = 1'b0;
        lanes(2'b11, 8'h55, 8'hAA);
        repeat (4) tick();
        lanes(2'b01, 8'h55, 8'hAA);
        expect_val("pat9_sat", 0, S_PAT, 4'd9);
        expect_val("pat9_cos", 2, S_PAT, 4'd9);
        tick();
        clear = 1'b1; snap_req = 1'b1;
        lanes(2'b11, 8'h55, 8'hAA);
        expect_val("clrsnap_spat", 0, S_SPAT, 4'd9);
        expect_val("clrsnap_seven", 0, S_SEVEN, 4'd9);
        expect_val("clrsnap_pat", 0, S_PAT, 4'd0);
        expect_val("clrsnap_even", 0, S_EVEN, 4'd0);
        expect_val("clrsnap_sv", 0, S_SVALID, 4'd1);
        expect_val("cos_clrsnap_spat", 2, S_SPAT, 4'd9);
        expect_val("cos_clr_wins", 2, S_PAT, 4'd0);
        expect_val("cos_clr_wins_e", 2, S_EVEN, 4'd0);
        tick();
        clear = 1'b0; snap_req = 1'b0;
        expect_val("hold_pat", 0, S_PAT, 4'd2);
        expect_val("hold_sv", 0, S_SVALID, 4'd1);
        expect_val("hold_spat", 0, S_SPAT, 4'd9);
        expect_val("cos_hold_pat", 2, S_PAT, 4'd2);
        tick();
        snap_ack = 1'b1; snap_req = 1'b1;
        expect_val("reack_spat", 0, S_SPAT, 4'd2);
        expect_val("reack_pat", 0, S_PAT, 4'd4);
        expect_val("reack_sv", 0, S_SVALID, 4'd1);
        expect_val("cos_reack_spat", 2, S_SPAT, 4'd2);
        expect_val("cos_reack_pat", 2, S_PAT, 4'd2);
        expect_val("cos_reack_sv", 2, S_SVALID, 4'd1);
        tick();
        snap_req = 1'b0;
        lanes(2'b00, 8'h55, 8'hAA);
        expect_val("final_ack_sv", 0, S_SVALID, 4'd0);
        expect_val("final_ack_spat", 0, S_SPAT, 4'd2);
        expect_val("cos_final_sv", 2, S_SVALID, 4'd0);
        tick();
        snap_ack = 1'b0;

        // Identical patterns count a word once
        pattern_b = 8'hAA;
        lanes(2'b11, 8'h00, 8'hAA);
        expect_val("same_pat_once", 0, S_PAT, 4'd5);
        expect_val("cos_same_pat_once", 2, S_PAT, 4'd3);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
